// File: rtl/urv_dm_wb_bridge_if.sv
// rtl/urv_dm_wb_bridge_if.sv - Wishbone B4 pipelined bus bundle for the uRV data-memory bridge
interface urv_dm_wb_bridge_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_stall_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
    );
endinterface

// File: rtl/urv_dm_wb_bridge.sv
// rtl/urv_dm_wb_bridge.sv - uRV dm_* strobes to single Wishbone B4 pipelined cycles (optional URV_DM_BRIDGE_TIMEOUT_EN)
module urv_dm_wb_bridge #(
    parameter int g_timeout_cycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_bus_err_o,
    urv_dm_wb_bridge_if.master wb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_q;
    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        ready_q;
    logic [31:0] data_l_q;
    logic        load_done_q;
    logic        store_done_q;
    logic        bus_err_q;

    logic        bus_term;
    logic        tmo_hit;
    logic        end_is_err;

`ifdef URV_DM_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(g_timeout_cycles - 1);
    logic [15:0] tmo_cnt_q;
`endif

    // Termination sources: ack/err only count once stb has been accepted (not stalled).
    always_comb begin
        bus_term = 1'b0;
        tmo_hit  = 1'b0;
        if (state_q == ST_WAIT) begin
            bus_term = wb.wb_ack_i | wb.wb_err_i;
        end else if (state_q == ST_REQ) begin
            bus_term = (wb.wb_ack_i | wb.wb_err_i) & ~wb.wb_stall_i;
        end
`ifdef URV_DM_BRIDGE_TIMEOUT_EN
        if ((state_q != ST_IDLE) && !bus_term && (tmo_cnt_q == TMO_LAST)) begin
            tmo_hit = 1'b1;
        end
`endif
        end_is_err = tmo_hit | wb.wb_err_i;
    end

    // Request FSM with all bus and CPU-side outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            ready_q      <= 1'b1;
            data_l_q     <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
`ifdef URV_DM_BRIDGE_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dm_store_i || dm_load_i) begin
                        // A simultaneous load is dropped: the store takes the slot.
                        adr_q   <= dm_addr_i;
                        dat_q   <= dm_data_s_i;
                        sel_q   <= dm_data_select_i;
                        we_q    <= dm_store_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= ST_REQ;
`ifdef URV_DM_BRIDGE_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (bus_term || tmo_hit) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        ready_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                        bus_err_q <= end_is_err;
                        if (we_q) begin
                            store_done_q <= 1'b1;
                        end else begin
                            load_done_q <= 1'b1;
                            data_l_q    <= end_is_err ? 32'h0 : wb.wb_dat_i;
                        end
                    end else if ((state_q == ST_REQ) && !wb.wb_stall_i) begin
                        stb_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end
`ifdef URV_DM_BRIDGE_TIMEOUT_EN
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
                end
                default: begin
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dm_ready_o      = ready_q;
    assign dm_data_l_o     = data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_bus_err_o    = bus_err_q;
    assign wb.wb_cyc_o     = cyc_q;
    assign wb.wb_stb_o     = stb_q;
    assign wb.wb_we_o      = we_q;
    assign wb.wb_adr_o     = adr_q;
    assign wb.wb_dat_o     = dat_q;
    assign wb.wb_sel_o     = sel_q;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// tb/tb_urv_dm_wb_bridge.sv - bench for urv_dm_wb_bridge (URV_DM_BRIDGE_TIMEOUT_EN selects the timeout scenario)
module tb_urv_dm_wb_bridge;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_data_s = '0;
    logic [3:0]  dm_sel = '0;
    logic        dm_load = 1'b0;
    logic        dm_store = 1'b0;
    logic        dm_ready;
    logic [31:0] dm_data_l;
    logic        dm_load_done;
    logic        dm_store_done;
    logic        dm_bus_err;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 0;

    urv_dm_wb_bridge_if wb_if ();

    urv_dm_wb_bridge #(.g_timeout_cycles(TMO)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .dm_addr_i        (dm_addr),
        .dm_data_s_i      (dm_data_s),
        .dm_data_select_i (dm_sel),
        .dm_load_i        (dm_load),
        .dm_store_i       (dm_store),
        .dm_ready_o       (dm_ready),
        .dm_data_l_o      (dm_data_l),
        .dm_load_done_o   (dm_load_done),
        .dm_store_done_o  (dm_store_done),
        .dm_bus_err_o     (dm_bus_err),
        .wb               (wb_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding request, described by bus rules.
    logic        e_cyc = 0, e_stb = 0, e_we = 0, e_ld = 0, e_sd = 0, e_be = 0;
    logic [31:0] e_adr = 0, e_dat = 0, e_dl = 0;
    logic [3:0]  e_sel = 0;
    int          e_age = 0;

    always @(posedge clk) begin
        logic taken, timed_out, failed;
        e_ld = 0; e_sd = 0; e_be = 0;
        if (rst) begin
            e_cyc = 0; e_stb = 0; e_we = 0; e_adr = 0; e_dat = 0; e_sel = 0; e_dl = 0;
        end else if (!e_cyc) begin
            if (dm_store || dm_load) begin
                e_adr = dm_addr; e_dat = dm_data_s; e_sel = dm_sel; e_we = dm_store;
                e_cyc = 1; e_stb = 1; e_age = 0;
            end
        end else begin
            taken = (wb_if.wb_ack_i || wb_if.wb_err_i) && !(e_stb && wb_if.wb_stall_i);
            e_age++;
            timed_out = 0;
`ifdef URV_DM_BRIDGE_TIMEOUT_EN
            timed_out = !taken && (e_age == TMO);
`endif
            if (taken || timed_out) begin
                failed = wb_if.wb_err_i || timed_out;
                e_cyc = 0; e_stb = 0; e_be = failed;
                if (e_we) e_sd = 1;
                else begin
                    e_ld = 1;
                    e_dl = failed ? 32'h0 : wb_if.wb_dat_i;
                end
            end else if (e_stb && !wb_if.wb_stall_i) begin
                e_stb = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_ready", {31'b0, dm_ready}, {31'b0, !e_cyc});
            chk("m_data_l", dm_data_l, e_dl);
            chk("m_load_done", {31'b0, dm_load_done}, {31'b0, e_ld});
            chk("m_store_done", {31'b0, dm_store_done}, {31'b0, e_sd});
            chk("m_bus_err", {31'b0, dm_bus_err}, {31'b0, e_be});
            chk("m_cyc", {31'b0, wb_if.wb_cyc_o}, {31'b0, e_cyc});
            chk("m_stb", {31'b0, wb_if.wb_stb_o}, {31'b0, e_stb});
            chk("m_we", {31'b0, wb_if.wb_we_o}, {31'b0, e_we});
            chk("m_adr", wb_if.wb_adr_o, e_adr);
            chk("m_dat", wb_if.wb_dat_o, e_dat);
            chk("m_sel", {28'b0, wb_if.wb_sel_o}, {28'b0, e_sel});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe(input logic ld, input logic st, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        dm_load = ld; dm_store = st; dm_addr = a; dm_data_s = d; dm_sel = s;
        tick();
        dm_load = 0; dm_store = 0;
    endtask

    initial begin
        int stb_cnt, sd_cnt, ld_cnt, done_at, hi;
        logic cyc_hist [1:5];
        wb_if.wb_dat_i = '0; wb_if.wb_ack_i = 0; wb_if.wb_err_i = 0; wb_if.wb_stall_i = 0;
        tick(); tick();
        cmp_en = 1;
        chk("rst_ready", {31'b0, dm_ready}, 32'd1);
        chk("rst_cyc", {31'b0, wb_if.wb_cyc_o}, 32'd0);
        chk("rst_adr", wb_if.wb_adr_o, 32'd0);
        chk("rst_data_l", dm_data_l, 32'd0);
        rst = 0;
        tick();

        // Zero-wait load
        strobe(1, 0, 32'h0000_1000, 32'h0, 4'hF);
        chk("t1_stb", {31'b0, wb_if.wb_stb_o}, 32'd1);
        chk("t1_we", {31'b0, wb_if.wb_we_o}, 32'd0);
        chk("t1_sel", {28'b0, wb_if.wb_sel_o}, 32'hF);
        chk("t1_ready", {31'b0, dm_ready}, 32'd0);
        wb_if.wb_ack_i = 1; wb_if.wb_dat_i = 32'hCAFE_BABE;
        tick();
        wb_if.wb_ack_i = 0;
        chk("t1_done", {31'b0, dm_load_done}, 32'd1);
        chk("t1_data", dm_data_l, 32'hCAFE_BABE);
        chk("t1_ready2", {31'b0, dm_ready}, 32'd1);
        tick();
        chk("t1_hold", dm_data_l, 32'hCAFE_BABE);

        // Stalled store; ack during stall and strobe while busy are both ignored
        strobe(0, 1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
        stb_cnt = 0; sd_cnt = 0; ld_cnt = 0; done_at = 0;
        for (int k = 1; k <= 9; k++) begin
            if (wb_if.wb_stb_o) stb_cnt++;
            if (dm_store_done) begin sd_cnt++; done_at = k; end
            if (dm_load_done) ld_cnt++;
            if (k == 1) chk("t2_dat", wb_if.wb_dat_o, 32'h1234_5678);
            wb_if.wb_stall_i = (k <= 3);
            wb_if.wb_ack_i = (k == 2 || k == 6);
            dm_load = (k == 4);
            tick();
        end
        wb_if.wb_stall_i = 0; wb_if.wb_ack_i = 0; dm_load = 0;
        chk("t2_stb_cycles", stb_cnt, 32'd4);
        chk("t2_store_done_cnt", sd_cnt, 32'd1);
        chk("t2_load_done_cnt", ld_cnt, 32'd0);
        chk("t2_done_cycle", done_at, 32'd7);

        // Back-to-back: load strobed in the store's done cycle
        strobe(0, 1, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF);
        for (int k = 1; k <= 5; k++) begin
            cyc_hist[k] = wb_if.wb_cyc_o;
            wb_if.wb_ack_i = (k == 1 || k == 3);
            dm_load = (k == 2);
            if (k == 2) begin
                chk("t3_store_done", {31'b0, dm_store_done}, 32'd1);
                dm_addr = 32'h0000_3004;
            end
            if (k == 3) wb_if.wb_dat_i = 32'hA5A5_0001;
            if (k == 4) chk("t3_load_data", dm_data_l, 32'hA5A5_0001);
            tick();
        end
        wb_if.wb_ack_i = 0; dm_load = 0;
        chk("t3_cyc_gap", {29'b0, cyc_hist[1], cyc_hist[2], cyc_hist[3]}, 32'b101);

        // Error on a load
        strobe(1, 0, 32'h0000_4000, 32'h0, 4'b1000);
        tick();
        wb_if.wb_err_i = 1; wb_if.wb_dat_i = 32'hFFFF_FFFF;
        tick();
        wb_if.wb_err_i = 0;
        chk("t4_done", {31'b0, dm_load_done}, 32'd1);
        chk("t4_err", {31'b0, dm_bus_err}, 32'd1);
        chk("t4_data", dm_data_l, 32'd0);

        // Reset in WAIT, then a late ack
        strobe(1, 0, 32'h0000_5000, 32'h0, 4'hF);
        tick();
        chk("t5_wait_stb", {31'b0, wb_if.wb_stb_o}, 32'd0);
        rst = 1;
        tick();
        rst = 0;
        chk("t5_cyc", {31'b0, wb_if.wb_cyc_o}, 32'd0);
        wb_if.wb_ack_i = 1; wb_if.wb_dat_i = 32'h0000_1234;
        tick();
        wb_if.wb_ack_i = 0;
        chk("t5_no_done", {30'b0, dm_load_done, dm_store_done}, 32'd0);

        // Store and load together; ack with err
        strobe(1, 1, 32'h0000_6000, 32'h55AA_55AA, 4'b0110);
        chk("t6_we", {31'b0, wb_if.wb_we_o}, 32'd1);
        wb_if.wb_ack_i = 1; wb_if.wb_err_i = 1;
        tick();
        wb_if.wb_ack_i = 0; wb_if.wb_err_i = 0;
        chk("t6_done", {29'b0, dm_store_done, dm_load_done, dm_bus_err}, 32'b101);

`ifdef URV_DM_BRIDGE_TIMEOUT_EN
        strobe(0, 1, 32'h0000_7000, 32'h7777_7777, 4'hF);
        done_at = 0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            if (dm_store_done) begin
                done_at = k;
                chk("t7_err", {31'b0, dm_bus_err}, 32'd1);
            end
            tick();
        end
        chk("t7_abort_cycle", done_at, 32'd17);
`else
        strobe(1, 0, 32'h0000_7000, 32'h0, 4'hF);
        hi = 0;
        for (int k = 1; k <= 1000; k++) begin
            if (wb_if.wb_cyc_o) hi++;
            tick();
        end
        chk("t7_cyc_held", hi, 32'd1000);
        wb_if.wb_ack_i = 1; wb_if.wb_dat_i = 32'h0BAD_F00D;
        tick();
        wb_if.wb_ack_i = 0;
        chk("t7_late_done", {31'b0, dm_load_done}, 32'd1);
`endif
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
